// File: rtl/zx_clock_reset.sv
// Reset sequencer and clock-enable generator for the Spectrum core.
// Waits for PLL lock, holds system reset for RESET_CYCLES, then issues pixel, CPU and PSG enables.
module zx_clock_reset #(
  parameter int RESET_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic [1:0] turbo,
  input  logic       cpu_wait,
  output logic       sys_rst_n,
  output logic       ce_pix,
  output logic       ce_cpu_p,
  output logic       ce_cpu_n,
  output logic       ce_psg
);

  localparam int CNT_W = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             lock_meta_r;
  logic             lock_sync_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       div_r;
  logic [1:0]       turbo_q_r;
  logic             skip_r;
  logic             ce_pix_r;
  logic             ce_cpu_p_r;
  logic             ce_cpu_n_r;
  logic             ce_psg_r;
  logic             run_s;
  logic             count_s;
  logic             sys_rst_s;
  logic             p_match_s;
  logic             n_match_s;

  // CPU phase match decode: {P, N}. Each mode's N lands on div[2:0]==7 so turbo can switch there.
  function automatic logic [1:0] cpu_match(input logic [1:0] mode, input logic [3:0] div);
    logic [1:0] m;
    case (mode)
      2'd1:    m = {div[1:0] == 2'd1, div[1:0] == 2'd3};
      2'd2:    m = {div[0] == 1'b0, div[0] == 1'b1};
      default: m = {div[2:0] == 3'd3, div[2:0] == 3'd7};
    endcase
    return m;
  endfunction

  // Two-flop synchronizer for the asynchronous PLL lock flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= pll_locked;
      lock_sync_r <= lock_meta_r;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_HOLD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HOLD: begin
        if (lock_sync_r) state_nxt_s = ST_COUNT;
        else             state_nxt_s = ST_HOLD;
      end
      ST_COUNT: begin
        if (!lock_sync_r)          state_nxt_s = ST_HOLD;
        else if (cnt_r == CNT_LAST) state_nxt_s = ST_RUN;
        else                       state_nxt_s = ST_COUNT;
      end
      ST_RUN: begin
        if (!lock_sync_r) state_nxt_s = ST_HOLD;
        else              state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_HOLD;
    endcase
  end

  // Output decode; run_s also excludes the entry and exit edges so div and enables start/stop cleanly
  always_comb begin
    sys_rst_s = (state_r == ST_RUN);
    run_s     = (state_r == ST_RUN) && (state_nxt_s == ST_RUN);
    count_s   = (state_r == ST_COUNT) && (state_nxt_s == ST_COUNT);
    {p_match_s, n_match_s} = cpu_match(turbo_q_r, div_r);
  end

  // Reset-interval counter and free-running divider
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      div_r <= 4'd0;
    end else begin
      cnt_r <= count_s ? cnt_r + {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
      div_r <= run_s ? div_r + 4'd1 : 4'd0;
    end
  end

  // Turbo select, sampled only on a period boundary common to every mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      turbo_q_r <= 2'd0;
    end else if (run_s && (div_r[2:0] == 3'd7)) begin
      turbo_q_r <= turbo;
    end else begin
      turbo_q_r <= turbo_q_r;
    end
  end

  // Registered enables; a stalled P arms skip so the matching N is dropped too
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skip_r     <= 1'b0;
      ce_pix_r   <= 1'b0;
      ce_cpu_p_r <= 1'b0;
      ce_cpu_n_r <= 1'b0;
      ce_psg_r   <= 1'b0;
    end else begin
      ce_pix_r   <= run_s && (div_r[1:0] == 2'd3);
      ce_psg_r   <= run_s && (div_r == 4'd15);
      ce_cpu_p_r <= run_s && p_match_s && !cpu_wait;
      ce_cpu_n_r <= run_s && n_match_s && !skip_r;
      if (!run_s) begin
        skip_r <= 1'b0;
      end else if (p_match_s) begin
        skip_r <= cpu_wait;
      end else if (n_match_s) begin
        skip_r <= 1'b0;
      end else begin
        skip_r <= skip_r;
      end
    end
  end

  assign sys_rst_n = sys_rst_s;
  assign ce_pix    = ce_pix_r;
  assign ce_cpu_p  = ce_cpu_p_r;
  assign ce_cpu_n  = ce_cpu_n_r;
  assign ce_psg    = ce_psg_r;

endmodule

// File: tb/tb_zx_clock_reset.sv
// Directed bench for zx_clock_reset (RESET_CYCLES=16); outputs are logged per edge and
// checked against hand-computed edge numbers.
module tb_zx_clock_reset;

  localparam int RC = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic [1:0] turbo;
  logic       cpu_wait;
  logic       sys_rst_n;
  logic       ce_pix;
  logic       ce_cpu_p;
  logic       ce_cpu_n;
  logic       ce_psg;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  logic log_sys [0:511];
  logic log_pix [0:511];
  logic log_p   [0:511];
  logic log_n   [0:511];
  logic log_psg [0:511];

  zx_clock_reset #(.RESET_CYCLES(RC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .turbo      (turbo),
    .cpu_wait   (cpu_wait),
    .sys_rst_n  (sys_rst_n),
    .ce_pix     (ce_pix),
    .ce_cpu_p   (ce_cpu_p),
    .ce_cpu_n   (ce_cpu_n),
    .ce_psg     (ce_psg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // log[e] holds the outputs seen after posedge number e
  always @(negedge clk) begin
    if (edge_n < 512) begin
      log_sys[edge_n] = sys_rst_n;
      log_pix[edge_n] = ce_pix;
      log_p[edge_n]   = ce_cpu_p;
      log_n[edge_n]   = ce_cpu_n;
      log_psg[edge_n] = ce_psg;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  function automatic int sig(input int sel, input int e);
    logic v;
    case (sel)
      0:       v = log_sys[e];
      1:       v = log_pix[e];
      2:       v = log_p[e];
      3:       v = log_n[e];
      default: v = log_psg[e];
    endcase
    return (v === 1'b1) ? 1 : 0;
  endfunction

  function automatic int ones(input int sel, input int a, input int b);
    int c = 0;
    for (int e = a; e <= b; e++) c += sig(sel, e);
    return c;
  endfunction

  function automatic int first_high(input int sel, input int a, input int b);
    for (int e = a; e <= b; e++) if (sig(sel, e) == 1) return e;
    return -1;
  endfunction

  function automatic int overlap_pn(input int a, input int b);
    int c = 0;
    for (int e = a; e <= b; e++) c += sig(2, e) & sig(3, e);
    return c;
  endfunction

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; turbo = 2'd0; cpu_wait = 1'b0;
    step_to(2);
    chk("rst_sys", sig(0, 2), 0);
    chk("rst_pix", sig(1, 2), 0);
    chk("rst_p",   sig(2, 2), 0);
    chk("rst_n",   sig(3, 2), 0);
    chk("rst_psg", sig(4, 2), 0);
    rst_n = 1'b1;

    // lock first sampled at edge 11 -> RUN after edge 11+RC+2 = 29
    step_to(10); pll_locked = 1'b1;
    step_to(92);
    chk("lock_pre_run", sig(0, 28), 0);
    chk("lock_run",     sig(0, 29), 1);
    chk("ce_quiet", ones(1,1,28) + ones(2,1,28) + ones(3,1,28) + ones(4,1,28), 0);
    chk("pix_first", first_high(1, 29, 92), 33);
    chk("pix_count", ones(1, 29, 92), 15);
    chk("psg_first", first_high(4, 29, 92), 45);
    chk("psg_count", ones(4, 29, 92), 3);
    chk("p8_first",  first_high(2, 29, 92), 33);
    chk("n8_first",  first_high(3, 29, 92), 37);
    chk("p8_count",  ones(2, 29, 92), 8);
    chk("n8_count",  ones(3, 29, 92), 7);
    chk("pn_overlap", overlap_pn(29, 92), 0);

    // turbo 0->2 while div[2:0]==2; /2 starts after the div[2:0]==7 edge (edge 101)
    step_to(95); turbo = 2'd2;
    step_to(110);
    chk("sw_p_old",  sig(2, 97), 1);
    chk("sw_n_old",  sig(3, 101), 1);
    chk("sw_p_cnt",  ones(2, 96, 101), 1);
    chk("sw_n_cnt",  ones(3, 96, 101), 1);
    chk("t2_p_cnt",  ones(2, 102, 109), 4);
    chk("t2_n_cnt",  ones(3, 102, 109), 4);
    chk("t2_p_first", first_high(2, 102, 109), 102);

    // turbo 1, single-cycle stall on the P match in cycle 94
    turbo = 2'd1;
    step_to(122); cpu_wait = 1'b1;
    step_to(123); cpu_wait = 1'b0;
    step_to(130);
    chk("w1_p_before", sig(2, 119), 1);
    chk("w1_n_before", sig(3, 121), 1);
    chk("w1_p_stall",  sig(2, 123), 0);
    chk("w1_n_stall",  sig(3, 125), 0);
    chk("w1_p_after",  sig(2, 127), 1);
    chk("w1_n_after",  sig(3, 129), 1);
    chk("w1_pix",      ones(1, 118, 129), 3);

    // turbo 0, cpu_wait over three full /8 periods
    turbo = 2'd0;
    step_to(133); cpu_wait = 1'b1;
    step_to(157); cpu_wait = 1'b0;
    step_to(166);
    chk("w3_p_none",  ones(2, 134, 157), 0);
    chk("w3_n_none",  ones(3, 134, 157), 0);
    chk("w3_pix",     ones(1, 134, 157), 6);
    chk("w3_p_gap",   ones(2, 158, 160), 0);
    chk("w3_p_resume", sig(2, 161), 1);
    chk("w3_n_resume", sig(3, 165), 1);

    // lock drop in RUN, sampled low at edge 167
    pll_locked = 1'b0;
    step_to(170); pll_locked = 1'b1;
    chk("drop_sys_l1", sig(0, 168), 1);
    chk("drop_sys_l2", sig(0, 169), 0);
    chk("drop_pix",    sig(1, 169), 0);
    chk("drop_p",      sig(2, 169), 0);

    // one-cycle glitch mid-COUNT restarts the full interval
    step_to(178); pll_locked = 1'b0;
    step_to(179); pll_locked = 1'b1;
    step_to(203);
    chk("glitch_no_early", sig(0, 189), 0);
    chk("glitch_pre_run",  sig(0, 197), 0);
    chk("glitch_run",      sig(0, 198), 1);
    chk("glitch_div0",     first_high(1, 198, 202), 202);

    // turbo_q=2, then a one-cycle rst_n pulse sampled at edge 211
    turbo = 2'd2;
    step_to(210); rst_n = 1'b0;
    step_to(211); rst_n = 1'b1;
    step_to(240);
    chk("t2_active",   sig(2, 207), 1);
    chk("srst_sys",    sig(0, 211), 0);
    chk("srst_p",      sig(2, 211), 0);
    chk("srst_pre_run", sig(0, 229), 0);
    chk("srst_run",    sig(0, 230), 1);
    chk("srst_tq0_gap", ones(2, 230, 233), 0);
    chk("srst_tq0_p",  sig(2, 234), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/zx_clock_reset.md
# zx_clock_reset

Reset sequencer and clock-enable generator for the Spectrum core, clocked by the PLL's 28.4091 MHz output. It waits for PLL lock, then holds system reset for a programmable interval. Once running, it divides the system clock into single-cycle enables: pixel/ULA (7.1 MHz), CPU (3.55/7.1/14.2 MHz selectable, with T80-style positive/negative-phase pairs and a contention stall input), and PSG (1.78 MHz).

## Interface
Parameters:
- RESET_CYCLES, 1024: RUN-entry delay after synchronized lock, in clk cycles (legal range 2..65535; counter width is clog2(RESET_CYCLES)).

Ports:
- clk  in  1  system clock, 28.4091 MHz PLL output; the block's only clock.
- rst_n  in  1  synchronous, active-low reset.
- pll_locked  in  1  PLL lock flag, asynchronous to clk.
- turbo  in  2  CPU speed select: 0 = /8, 1 = /4, 2 = /2, 3 = same as 0.
- cpu_wait  in  1  contention stall request, synchronous to clk.
- sys_rst_n  out  1  active-low reset for the rest of the core.
- ce_pix  out  1  pixel/ULA enable, 1 cycle in 4.
- ce_cpu_p  out  1  CPU positive-phase enable.
- ce_cpu_n  out  1  CPU negative-phase enable.
- ce_psg  out  1  PSG enable, 1 cycle in 16.

## Operation
- Lock synchronizer: 2 flops, lock_s = second stage.
- FSM states:
  - HOLD: wait for lock_s=1, then go to COUNT with cnt=0.
  - COUNT: cnt+1 per cycle. If lock_s=0, return to HOLD. At cnt==RESET_CYCLES-1, go to RUN.
  - RUN: if lock_s=0, go to HOLD.
- sys_rst_n = (state==RUN), decoded from the state register.
- div[3:0]:
  - Outside RUN: held at 0.
  - In RUN: free-runs, wraps 15→0.
- Registered enables. Outside RUN all are 0. In RUN, each enable is set the cycle after its div match:
  - ce_pix: div[1:0]==3.
  - ce_psg: div==15.
- CPU period, match values on div (using turbo_q):
  - turbo_q 0 or 3: P at div[2:0]==3, N at div[2:0]==7.
  - turbo_q 1: P at div[1:0]==1, N at div[1:0]==3.
  - turbo_q 2: P at div[0]==0, N at div[0]==1.
- turbo_q:
  - Reset value 0.
  - Loads turbo only in RUN when div[2:0]==7, which is a period boundary for every mode.
  - Mid-period changes have no effect until that boundary.
- cpu_wait:
  - If cpu_wait=1 at a P match, ce_cpu_p is suppressed and skip is set.
  - At the next N match, if skip=1, ce_cpu_n is suppressed and skip is cleared. Otherwise ce_cpu_n fires.
  - cpu_wait never affects ce_cpu_n directly. N fires iff the P of the same period fired.
- rst_n=0 at an edge clears: state→HOLD, sync flops, cnt, div, turbo_q, skip, all ce. This holds in any state, including mid-COUNT or in RUN.

## Timing
- Reset values: sys_rst_n=0, ce_pix=ce_cpu_p=ce_cpu_n=ce_psg=0.
- pll_locked first sampled high at edge E1:
  - lock_s=1 after E2.
  - COUNT (cnt=0) after E3.
  - RUN, with sys_rst_n=1, after edge E(RESET_CYCLES+3).
- RUN cycle k (k=1 is the first cycle with sys_rst_n=1) has div=k-1:
  - First ce_pix in cycle 5.
  - First ce_psg in cycle 17.
  - turbo 0: first ce_cpu_p in cycle 5, first ce_cpu_n in cycle 9.
- Lock loss: pll_locked sampled low at edge L. HOLD, with sys_rst_n=0 and all ce=0, after edge L+2.
- A lock glitch during COUNT restarts the full RESET_CYCLES delay.
- Each enable is high for exactly one cycle. ce_cpu_p and ce_cpu_n are never high in the same cycle.
- cpu_wait-to-ce latency is one edge: registered, with no combinational path to the outputs.

## Test plan
- RESET_CYCLES=16, rst_n=1, pll_locked rises at edge 10 → sys_rst_n rises after edge 29; all ce stay 0 before that.
- Running, turbo=0 → ce_pix period 4, ce_psg period 16, ce_cpu_p and ce_cpu_n each period 8, N always 4 cycles after P. Then turbo 0→2 with div[2:0]=2 → old /8 pattern completes, and /2 pattern (P,N alternating) starts after the next div[2:0]==7 edge.
- turbo=1, cpu_wait pulsed high for the cycle of one P match → that P and the following N are both missing; the next period's P and N appear normally; ce_pix is unaffected.
- cpu_wait held high for 3 full /8 periods → zero ce_cpu_p and zero ce_cpu_n; release → first P at the next P match, followed by its N.
- pll_locked drops for 1 cycle mid-COUNT (RESET_CYCLES=16) → back to HOLD, full 16-cycle count restarts. Drop in RUN → sys_rst_n=0 and all ce=0 two edges after sampling, div=0.
- rst_n pulsed low for 1 cycle in RUN with turbo_q=2 → sys_rst_n=0 and ce=0 after that edge, turbo_q=0. With pll_locked still 1, sys_rst_n returns RESET_CYCLES+3 edges after the rst_n-low edge.
